// File: rtl/parc_core_rob_ctrl_pkg.sv
// parc_core_rob_ctrl_pkg: shared slot width, default depth and ROB entry layout
package parc_core_rob_ctrl_pkg;
    localparam int SLOT_W          = 5;
    localparam int DEFAULT_ENTRIES = 16;
    typedef struct packed {
        logic              valid;
        logic              pending;
        logic              spec;
        logic              squashed;
        logic [SLOT_W-1:0] preg;
    } rob_entry_t;
endpackage

// File: rtl/parc_core_rob_ctrl.sv
// parc_core_rob_ctrl: in-order ROB controller (alloc / fill / branch squash / in-order retire)
//   alloc:  rob_alloc_req_{val,rdy,preg,spec}, rob_alloc_resp_slot (tail)
//   fill:   rob_fill_{val,slot}
//   branch: rob_branch_res_{val,taken} (taken = mispredict)
//   commit: rob_commit_{wen,slot,rf_waddr} (head)
module parc_core_rob_ctrl
    import parc_core_rob_ctrl_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rob_alloc_req_val,
    output logic              rob_alloc_req_rdy,
    input  logic [SLOT_W-1:0] rob_alloc_req_preg,
    input  logic              rob_alloc_req_spec,
    output logic [SLOT_W-1:0] rob_alloc_resp_slot,
    input  logic              rob_fill_val,
    input  logic [SLOT_W-1:0] rob_fill_slot,
    input  logic              rob_branch_res_val,
    input  logic              rob_branch_res_taken,
    output logic              rob_commit_wen,
    output logic [SLOT_W-1:0] rob_commit_slot,
    output logic [SLOT_W-1:0] rob_commit_rf_waddr
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    rob_entry_t    ent [ENTRIES];
    logic [IW-1:0] head, tail;
    logic [IW:0]   count;
    rob_entry_t    hd;
    logic          retire, fire;

    assign hd                  = ent[head];
    // Squashed heads drain regardless of pending; live heads need fill and no speculation.
    assign retire              = hd.valid && (hd.squashed || (!hd.pending && !hd.spec));
    assign rob_commit_wen      = retire && !hd.squashed;
    assign rob_commit_slot     = SLOT_W'(head);
    assign rob_commit_rf_waddr = hd.preg;
    // Depends on registered count only, so commit never feeds rdy combinationally.
    assign rob_alloc_req_rdy   = count != (IW+1)'(ENTRIES);
    assign rob_alloc_resp_slot = SLOT_W'(tail);
    assign fire                = rob_alloc_req_val && rob_alloc_req_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ent[i].valid && rob_branch_res_val) begin
                    ent[i].spec <= 1'b0;
                    if (rob_branch_res_taken && ent[i].spec) ent[i].squashed <= 1'b1;
                end
                if (ent[i].valid && rob_fill_val && rob_fill_slot == SLOT_W'(i))
                    ent[i].pending <= 1'b0;
            end
            if (retire) begin
                ent[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            // The tail slot is never valid when fire is high, so branch/fill above cannot touch it.
            if (fire) begin
                ent[tail] <= '{valid: 1'b1, pending: 1'b1, spec: rob_alloc_req_spec,
                               squashed: 1'b0, preg: rob_alloc_req_preg};
                tail      <= tail + 1'b1;
            end
            count <= count + (IW+1)'(fire) - (IW+1)'(retire);
        end
    end
endmodule

// File: tb/tb_parc_core_rob_ctrl.sv
// tb_parc_core_rob_ctrl: directed self-checking bench for parc_core_rob_ctrl
module tb_parc_core_rob_ctrl;
    logic       clk = 0;
    logic       reset;
    logic       val, rdy, spec, fval, bval, btaken, wen;
    logic [4:0] preg, rslot, fslot, cslot, waddr;
    int         vecs = 0;
    int         errs = 0;

    parc_core_rob_ctrl #(.ENTRIES(16)) dut (
        .clk(clk), .reset(reset),
        .rob_alloc_req_val(val), .rob_alloc_req_rdy(rdy),
        .rob_alloc_req_preg(preg), .rob_alloc_req_spec(spec),
        .rob_alloc_resp_slot(rslot),
        .rob_fill_val(fval), .rob_fill_slot(fslot),
        .rob_branch_res_val(bval), .rob_branch_res_taken(btaken),
        .rob_commit_wen(wen), .rob_commit_slot(cslot), .rob_commit_rf_waddr(waddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        val = 0; preg = 0; spec = 0; fval = 0; fslot = 0; bval = 0; btaken = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic alloc(input logic [4:0] p, input logic s);
        val = 1; preg = p; spec = s;
        step();
        val = 0;
    endtask

    task automatic fill(input logic [4:0] s);
        fval = 1; fslot = s;
        step();
        fval = 0;
    endtask

    task automatic commit(input string tag, input logic w, input logic [4:0] s, input logic [4:0] a);
        chk({tag, ".wen"}, 32'(wen), 32'(w));
        chk({tag, ".slot"}, 32'(cslot), 32'(s));
        chk({tag, ".waddr"}, 32'(waddr), 32'(a));
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("rst.rdy", 32'(rdy), 1);
        chk("rst.resp", 32'(rslot), 0);
        commit("rst", 0, 0, 0);

        // basic in-order commit with out-of-order fills
        val = 1; preg = 3; spec = 0;
        chk("t1.resp0", 32'(rslot), 0); step();
        preg = 5; chk("t1.resp1", 32'(rslot), 1); step();
        preg = 7; chk("t1.resp2", 32'(rslot), 2); step();
        val = 0;
        commit("t1.pend", 0, 0, 3);
        fill(1);
        commit("t1.f1", 0, 0, 3);
        fill(0);
        commit("t1.c0", 1, 0, 3);
        step();
        commit("t1.c1", 1, 1, 5);
        step();
        commit("t1.hold2", 0, 2, 7);
        step();
        commit("t1.hold2b", 0, 2, 7);
        fill(2);
        commit("t1.c2", 1, 2, 7);
        step();
        commit("t1.empty", 0, 3, 0);
        chk("t1.tail", 32'(rslot), 3);

        // fill to full, blocked alloc, retire then wrap
        do_reset();
        val = 1; spec = 0;
        for (int i = 0; i < 16; i++) begin
            preg = 5'(i + 1);
            step();
        end
        chk("t2.full.rdy", 32'(rdy), 0);
        preg = 20;
        step();
        chk("t2.held.rdy", 32'(rdy), 0);
        chk("t2.held.resp", 32'(rslot), 0);
        commit("t2.held", 0, 0, 1);
        fval = 1; fslot = 0; step(); fval = 0;
        commit("t2.c0", 1, 0, 1);
        chk("t2.fullret.rdy", 32'(rdy), 0);
        step();
        chk("t2.after.rdy", 32'(rdy), 1);
        chk("t2.wrap.resp", 32'(rslot), 0);
        commit("t2.h1", 0, 1, 2);
        step();
        val = 0;
        chk("t2.refull.rdy", 32'(rdy), 0);
        chk("t2.refull.resp", 32'(rslot), 1);

        // mispredict: spec slots squash, pending squashed slot still drains
        do_reset();
        alloc(1, 0); alloc(2, 1); alloc(3, 1);
        fill(0);
        commit("t3.c0", 1, 0, 1);
        fill(1);
        commit("t3.stall", 0, 1, 2);
        bval = 1; btaken = 1; step(); bval = 0; btaken = 0;
        commit("t3.sq1", 0, 1, 2);
        step();
        commit("t3.sq2", 0, 2, 3);
        step();
        commit("t3.empty", 0, 3, 0);
        chk("t3.tail", 32'(rslot), 3);

        // correct prediction: all commit in order after resolution
        do_reset();
        alloc(1, 0); alloc(2, 1); alloc(3, 1);
        fill(0); fill(1); fill(2);
        commit("t4.stall", 0, 1, 2);
        step();
        commit("t4.stall2", 0, 1, 2);
        bval = 1; btaken = 0; step(); bval = 0;
        commit("t4.c1", 1, 1, 2);
        step();
        commit("t4.c2", 1, 2, 3);
        step();
        commit("t4.empty", 0, 3, 0);

        // same-cycle alloc + head fill + resolution
        do_reset();
        alloc(4, 1);
        val = 1; preg = 6; spec = 1; fval = 1; fslot = 0; bval = 1; btaken = 0;
        step();
        idle();
        commit("t5.c0", 1, 0, 4);
        step();
        commit("t5.new", 0, 1, 6);
        fill(1);
        commit("t5.keepspec", 0, 1, 6);
        bval = 1; step(); bval = 0;
        commit("t5.c1", 1, 1, 6);
        step();
        commit("t5.empty", 0, 2, 0);
        chk("t5.rdy", 32'(rdy), 1);

        // reset mid-stream with 5 valid entries
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(9 + i), 0);
        fill(0);
        commit("t6.pre", 1, 0, 9);
        val = 1; preg = 30; reset = 1;
        step();
        reset = 0; val = 0;
        chk("t6.rdy", 32'(rdy), 1);
        chk("t6.resp", 32'(rslot), 0);
        commit("t6", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
